// File: rtl/sprite_attr_fetch_if.sv
// Signal bundle between sprite RAM, the attribute fetcher and the sprite attribute table.
// The fetcher takes the master side and everything it talks to takes the slave side.
interface sprite_attr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int IW     = 3
) ();
    logic              vblank;
    logic [7:0]        sprite_RAM_din;
    logic [ADDR_W-1:0] sprite_RAM_addr;
    logic              rd_en;
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic [5:0]        wr_code;
    logic              wr_xflip;
    logic              wr_yflip;
    logic [7:0]        wr_palette;
    logic [7:0]        wr_x;
    logic [7:0]        wr_y;
    logic              busy;
    logic              done;
    logic              abort;

    modport master (
        input  vblank, sprite_RAM_din,
        output sprite_RAM_addr, rd_en, wr_en, wr_idx, wr_code, wr_xflip, wr_yflip,
               wr_palette, wr_x, wr_y, busy, done, abort
    );

    modport slave (
        output vblank, sprite_RAM_din,
        input  sprite_RAM_addr, rd_en, wr_en, wr_idx, wr_code, wr_xflip, wr_yflip,
               wr_palette, wr_x, wr_y, busy, done, abort
    );
endinterface

// File: rtl/sprite_attr_fetch.sv
// Per-vblank sprite attribute fetcher: streams 4 bytes per sprite out of sprite RAM, one read
// per cycle, and emits one decoded attribute-table write per sprite.
module sprite_attr_fetch #(
    parameter int                NUM_SPRITES = 8,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] ATTR_BASE   = ADDR_W'(16'h4FF0),
    parameter logic [ADDR_W-1:0] POS_BASE    = ADDR_W'(16'h5060),
    parameter int                RD_LAT      = 1,
    parameter int                REVERSE     = 0
) (
    input  logic clk,
    input  logic rst,
    sprite_attr_fetch_if.master bus
);
    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CW = $clog2(4 * NUM_SPRITES);
    localparam logic [CW-1:0] LAST_CNT = CW'(4 * NUM_SPRITES - 1);
    localparam logic [IW-1:0] LAST_SPR = (REVERSE != 0) ? '0 : IW'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] issue_cnt;
    logic          vblank_q;
    logic          fin_p2;
    logic          vld_p0  [RD_LAT];
    logic [1:0]    slot_p0 [RD_LAT];
    logic [IW-1:0] spr_p0  [RD_LAT];
    logic [5:0]    code_p1;
    logic          xflip_p1;
    logic          yflip_p1;
    logic [7:0]    pal_p1;
    logic [7:0]    x_p1;

    function automatic logic [IW-1:0] sprite_of(input logic [CW-1:0] cnt);
        logic [IW-1:0] s;
        s = IW'(cnt >> 2);
        return (REVERSE != 0) ? IW'(NUM_SPRITES - 1) - s : s;
    endfunction

    // Read order within a sprite: attr byte 0, attr byte 1, pos byte 0, pos byte 1.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [CW-1:0] cnt);
        logic [ADDR_W-1:0] base;
        base = cnt[1] ? POS_BASE : ATTR_BASE;
        return base + ADDR_W'({sprite_of(cnt), 1'b0}) + ADDR_W'(cnt[0]);
    endfunction

    logic          cap_vld;
    logic [1:0]    cap_slot;
    logic [IW-1:0] cap_spr;
    assign cap_vld  = vld_p0[RD_LAT-1];
    assign cap_slot = slot_p0[RD_LAT-1];
    assign cap_spr  = spr_p0[RD_LAT-1];

    // ---- p0: slot/sprite tags ride alongside the RAM latency; p1: byte collection ----
    always_ff @(posedge clk) begin
        slot_p0[0] <= issue_cnt[1:0];
        spr_p0[0]  <= sprite_of(issue_cnt);
        for (int i = 1; i < RD_LAT; i++) begin
            slot_p0[i] <= slot_p0[i-1];
            spr_p0[i]  <= spr_p0[i-1];
        end
        if (cap_vld) begin
            case (cap_slot)
                2'd0:    {code_p1, xflip_p1, yflip_p1} <= bus.sprite_RAM_din;
                2'd1:    pal_p1 <= bus.sprite_RAM_din;
                2'd2:    x_p1   <= bus.sprite_RAM_din;
                default: ;
            endcase
        end
    end

    // ---- control FSM, valid pipe and p2 write stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            issue_cnt           <= '0;
            vblank_q            <= 1'b1;
            fin_p2              <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) vld_p0[i] <= 1'b0;
            bus.sprite_RAM_addr <= '0;
            bus.rd_en           <= 1'b0;
            bus.wr_en           <= 1'b0;
            bus.wr_idx          <= '0;
            bus.wr_code         <= '0;
            bus.wr_xflip        <= 1'b0;
            bus.wr_yflip        <= 1'b0;
            bus.wr_palette      <= '0;
            bus.wr_x            <= '0;
            bus.wr_y            <= '0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.abort           <= 1'b0;
        end else begin
            vblank_q  <= bus.vblank;
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b0;
            bus.abort <= 1'b0;

            vld_p0[0] <= bus.rd_en;
            for (int i = 1; i < RD_LAT; i++) vld_p0[i] <= vld_p0[i-1];

            if (cap_vld && cap_slot == 2'd3) begin
                bus.wr_en      <= 1'b1;
                bus.wr_idx     <= cap_spr;
                bus.wr_code    <= code_p1;
                bus.wr_xflip   <= xflip_p1;
                bus.wr_yflip   <= yflip_p1;
                bus.wr_palette <= pal_p1;
                bus.wr_x       <= x_p1;
                bus.wr_y       <= bus.sprite_RAM_din;
                fin_p2         <= (cap_spr == LAST_SPR);
            end

            case (state)
                IDLE: begin
                    if (bus.vblank && !vblank_q) begin
                        state               <= ISSUE;
                        issue_cnt           <= '0;
                        bus.sprite_RAM_addr <= addr_of('0);
                        bus.rd_en           <= 1'b1;
                        bus.busy            <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_cnt == LAST_CNT) begin
                        bus.rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        issue_cnt           <= issue_cnt + 1'b1;
                        bus.sprite_RAM_addr <= addr_of(issue_cnt + 1'b1);
                    end
                end
                DRAIN: begin
                    if (fin_p2) begin
                        fin_p2   <= 1'b0;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Losing vblank overrides everything above, including a pending done.
            if (bus.busy && !bus.vblank) begin
                state      <= IDLE;
                bus.rd_en  <= 1'b0;
                bus.busy   <= 1'b0;
                bus.wr_en  <= 1'b0;
                bus.done   <= 1'b0;
                bus.abort  <= 1'b1;
                fin_p2     <= 1'b0;
                for (int i = 0; i < RD_LAT; i++) vld_p0[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sprite_attr_fetch.sv
// Directed bench: baseline, reverse-order and 3-cycle-latency fetchers share clk/rst/vblank,
// each backed by a RAM model that returns addr[7:0].
module tb_sprite_attr_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vblank = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_attr_fetch_if #(.ADDR_W(16), .IW(3)) b0 ();
    sprite_attr_fetch_if #(.ADDR_W(16), .IW(3)) b1 ();
    sprite_attr_fetch_if #(.ADDR_W(16), .IW(3)) b2 ();

    sprite_attr_fetch #(.NUM_SPRITES(8), .RD_LAT(1), .REVERSE(0)) u_base (.clk(clk), .rst(rst), .bus(b0));
    sprite_attr_fetch #(.NUM_SPRITES(8), .RD_LAT(1), .REVERSE(1)) u_rev  (.clk(clk), .rst(rst), .bus(b1));
    sprite_attr_fetch #(.NUM_SPRITES(8), .RD_LAT(3), .REVERSE(0)) u_lat3 (.clk(clk), .rst(rst), .bus(b2));

    logic [7:0] ram0_q, ram1_q;
    logic [7:0] ram2_q [3];
    always @(posedge clk) begin
        ram0_q    <= b0.sprite_RAM_addr[7:0];
        ram1_q    <= b1.sprite_RAM_addr[7:0];
        ram2_q[0] <= b2.sprite_RAM_addr[7:0];
        ram2_q[1] <= ram2_q[0];
        ram2_q[2] <= ram2_q[1];
    end
    assign b0.vblank = vblank;
    assign b1.vblank = vblank;
    assign b2.vblank = vblank;
    assign b0.sprite_RAM_din = ram0_q;
    assign b1.sprite_RAM_din = ram1_q;
    assign b2.sprite_RAM_din = ram2_q[2];

    typedef struct {
        int         cyc;
        int         idx;
        logic [5:0] code;
        logic       xf;
        logic       yf;
        logic [7:0] pal;
        logic [7:0] x;
        logic [7:0] y;
    } wr_t;

    wr_t         wr_q    [3][$];
    logic [15:0] rd_addr [3][$];
    int          done_q  [3][$];
    int          rd_n [3], rd_first [3], rd_last [3], abort_n [3], abort_cyc [3];

    task automatic mon(input int k, input logic rd, input logic [15:0] a, input logic wr,
                       input logic [2:0] idx, input logic [5:0] code, input logic xf, input logic yf,
                       input logic [7:0] pal, input logic [7:0] x, input logic [7:0] y,
                       input logic dn, input logic ab);
        wr_t w;
        if (rd) begin
            if (rd_n[k] == 0) rd_first[k] = cyc;
            rd_n[k]++;
            rd_last[k] = cyc;
            rd_addr[k].push_back(a);
        end
        if (wr) begin
            w = '{cyc, int'(idx), code, xf, yf, pal, x, y};
            wr_q[k].push_back(w);
        end
        if (dn) done_q[k].push_back(cyc);
        if (ab) begin
            abort_n[k]++;
            abort_cyc[k] = cyc;
        end
    endtask

    always @(negedge clk) begin
        mon(0, b0.rd_en, b0.sprite_RAM_addr, b0.wr_en, b0.wr_idx, b0.wr_code, b0.wr_xflip,
            b0.wr_yflip, b0.wr_palette, b0.wr_x, b0.wr_y, b0.done, b0.abort);
        mon(1, b1.rd_en, b1.sprite_RAM_addr, b1.wr_en, b1.wr_idx, b1.wr_code, b1.wr_xflip,
            b1.wr_yflip, b1.wr_palette, b1.wr_x, b1.wr_y, b1.done, b1.abort);
        mon(2, b2.rd_en, b2.sprite_RAM_addr, b2.wr_en, b2.wr_idx, b2.wr_code, b2.wr_xflip,
            b2.wr_yflip, b2.wr_palette, b2.wr_x, b2.wr_y, b2.done, b2.abort);
    end

    task automatic clear_logs();
        for (int k = 0; k < 3; k++) begin
            rd_n[k] = 0;
            rd_first[k] = 0;
            rd_last[k] = 0;
            abort_n[k] = 0;
            abort_cyc[k] = 0;
            rd_addr[k].delete();
            wr_q[k].delete();
            done_q[k].delete();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Relative cycle: first rd_en cycle of the pass is cycle 1.
    function automatic int rel(input int k, input int c);
        return c - rd_first[k] + 1;
    endfunction

    task automatic new_rise();
        vblank = 1'b0;
        tick(3);
        clear_logs();
        vblank = 1'b1;
    endtask

    initial begin
        logic [15:0] ea;
        int n;
        clear_logs();

        // Reset with vblank already high: outputs zero, and no pass after release.
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_rd_en", b0.rd_en, 0);
        chk("rst_addr", b0.sprite_RAM_addr, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_wr_en", b0.wr_en, 0);
        chk("rst_done_abort", {b0.done, b0.abort}, 0);
        chk("rst_wr_fields", {b0.wr_idx, b0.wr_code, b0.wr_palette, b0.wr_x, b0.wr_y}, 0);
        tick(10);
        chk("no_start_high_at_reset", rd_n[0], 0);

        // Full passes on all three instances.
        new_rise();
        tick(5);
        chk("t1_busy_mid", b0.busy, 1);
        chk("t1_rd_en_mid", b0.rd_en, 1);
        tick(55);
        chk("t1_rd_count", rd_n[0], 32);
        chk("t1_rd_contiguous", rd_last[0] - rd_first[0] + 1, 32);
        for (int i = 0; i < 32 && i < rd_addr[0].size(); i++) begin
            ea = ((i % 4) < 2 ? 16'h4FF0 : 16'h5060) + 16'(2 * (i / 4)) + 16'(i % 2);
            chk($sformatf("t1_addr%0d", i), rd_addr[0][i], ea);
        end
        chk("t1_addr4_hand", rd_addr[0].size() > 4 ? rd_addr[0][4] : 16'h0, 16'h4FF2);
        chk("t1_wr_count", wr_q[0].size(), 8);
        for (int i = 0; i < wr_q[0].size(); i++) begin
            chk($sformatf("t1_wr%0d_cycle", i), rel(0, wr_q[0][i].cyc), 6 + 4 * i);
            chk($sformatf("t1_wr%0d_idx", i), wr_q[0][i].idx, i);
            chk($sformatf("t1_wr%0d_data", i),
                {wr_q[0][i].code, wr_q[0][i].xf, wr_q[0][i].yf, wr_q[0][i].pal, wr_q[0][i].x, wr_q[0][i].y},
                {8'(8'hF0 + 2 * i), 8'(8'hF1 + 2 * i), 8'(8'h60 + 2 * i), 8'(8'h61 + 2 * i)});
        end
        if (wr_q[0].size() >= 2) begin
            chk("t1_wr0_code", wr_q[0][0].code, 6'h3C);
            chk("t1_wr0_flips", {wr_q[0][0].xf, wr_q[0][0].yf}, 2'b00);
            chk("t1_wr0_pal_x_y", {wr_q[0][0].pal, wr_q[0][0].x, wr_q[0][0].y}, 24'hF16061);
            chk("t1_wr1_xflip", {wr_q[0][1].xf, wr_q[0][1].yf}, 2'b10);
        end
        chk("t1_done_count", done_q[0].size(), 1);
        chk("t1_done_cycle", done_q[0].size() > 0 ? rel(0, done_q[0][0]) : -1, 35);
        chk("t1_no_abort", abort_n[0], 0);
        chk("t1_busy_after", b0.busy, 0);

        // Reverse order.
        if (rd_addr[1].size() >= 4)
            chk("t2_first_addrs", {rd_addr[1][0], rd_addr[1][1], rd_addr[1][2], rd_addr[1][3]},
                {16'h4FFE, 16'h4FFF, 16'h506E, 16'h506F});
        else chk("t2_first_addrs_present", rd_addr[1].size(), 4);
        chk("t2_wr_count", wr_q[1].size(), 8);
        for (int i = 0; i < wr_q[1].size(); i++)
            chk($sformatf("t2_idx%0d", i), wr_q[1][i].idx, 7 - i);
        if (wr_q[1].size() > 0)
            chk("t2_wr7_fields",
                {wr_q[1][0].code, wr_q[1][0].xf, wr_q[1][0].yf, wr_q[1][0].pal, wr_q[1][0].x, wr_q[1][0].y},
                {6'h3F, 1'b1, 1'b0, 8'hFF, 8'h6E, 8'h6F});
        chk("t2_done_count", done_q[1].size(), 1);

        // RD_LAT = 3.
        chk("t3_wr_count", wr_q[2].size(), 8);
        for (int i = 0; i < wr_q[2].size(); i++)
            chk($sformatf("t3_wr%0d_cycle", i), rel(2, wr_q[2][i].cyc), 8 + 4 * i);
        if (wr_q[2].size() > 0)
            chk("t3_wr0_fields",
                {wr_q[2][0].code, wr_q[2][0].xf, wr_q[2][0].yf, wr_q[2][0].pal, wr_q[2][0].x, wr_q[2][0].y},
                {6'h3C, 1'b0, 1'b0, 8'hF1, 8'h60, 8'h61});
        chk("t3_done_cycle", done_q[2].size() > 0 ? rel(2, done_q[2][0]) : -1, 37);

        // vblank stays high for roughly three pass lengths: still only one pass.
        tick(60);
        chk("t6_single_pass_rd", rd_n[0], 32);
        chk("t6_single_done", done_q[0].size(), 1);

        // Abort after 10 reads.
        new_rise();
        n = 0;
        for (int i = 0; i < 50 && n < 10; i++) begin
            tick(1);
            if (b0.rd_en) n++;
        end
        chk("t4_reached_10_reads", n, 10);
        vblank = 1'b0;
        tick(1);
        chk("t4_abort_pulse", b0.abort, 1);
        chk("t4_rd_en_off", b0.rd_en, 0);
        chk("t4_busy_off", b0.busy, 0);
        tick(1);
        chk("t4_abort_one_cycle", b0.abort, 0);
        tick(40);
        chk("t4_rd_count", rd_n[0], 10);
        chk("t4_abort_count", abort_n[0], 1);
        chk("t4_abort_cycle", rel(0, abort_cyc[0]), 11);
        chk("t4_wr_count", wr_q[0].size(), 2);
        chk("t4_no_done", done_q[0].size(), 0);
        new_rise();
        tick(6);
        chk("t4_restart_addr", rd_addr[0].size() > 0 ? rd_addr[0][0] : 16'h0, 16'h4FF0);

        // Reset mid-pass with vblank held high.
        for (int i = 0; i < 50 && rd_n[0] < 15; i++) tick(1);
        chk("t5_mid_pass", b0.busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_outputs", {b0.rd_en, b0.busy, b0.wr_en, b0.done, b0.abort}, 0);
        chk("t5_rst_addr", b0.sprite_RAM_addr, 0);
        clear_logs();
        tick(2);
        rst = 1'b0;
        tick(50);
        chk("t5_no_reads", rd_n[0], 0);
        chk("t5_no_writes", wr_q[0].size(), 0);
        chk("t5_no_done", done_q[0].size(), 0);
        new_rise();
        tick(45);
        chk("t5_pass_writes", wr_q[0].size(), 8);
        chk("t5_pass_done", done_q[0].size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
